// File: rtl/md_iter_pkg.sv
// Shared op codes, widths and result payload for the E-stage multiply/divide unit.
package md_iter_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] MD_MFHI  = 4'd5;
   localparam logic [OP_W-1:0] MD_MFLO  = 4'd6;
   localparam logic [OP_W-1:0] MD_MTHI  = 4'd7;
   localparam logic [OP_W-1:0] MD_MTLO  = 4'd8;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } md_res_t;

   function automatic logic md_is_div(input logic [OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_start(input logic [OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational signed/unsigned 32x32 multiply and divide producing a HI/LO pair.
module md_calc
   import md_iter_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo,
   output logic              div_zero
);

   logic              is_signed;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [DATA_W-1:0] divisor;
   logic [DATA_W-1:0] quot;
   logic [DATA_W-1:0] rem;
   logic [2*DATA_W-1:0] prod;

   // Signed division works on magnitudes; -2^31 keeps its bit pattern as an unsigned 2^31.
   always_comb begin
      is_signed = (op == MD_DIV);
      div_zero  = md_is_div(op) && (b == '0);
      mag_a     = (is_signed && a[DATA_W-1]) ? DATA_W'(-a) : a;
      mag_b     = (is_signed && b[DATA_W-1]) ? DATA_W'(-b) : b;
      divisor   = (b == '0) ? DATA_W'(1) : mag_b;
      quot      = mag_a / divisor;
      rem       = mag_a % divisor;
      if (is_signed && (a[DATA_W-1] ^ b[DATA_W-1])) quot = DATA_W'(-quot);
      if (is_signed && a[DATA_W-1])                 rem  = DATA_W'(-rem);
   end

   always_comb begin
      prod   = '0;
      res_hi = '0;
      res_lo = '0;
      case (op)
         MD_MULT: begin
            prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
            {res_hi, res_lo} = prod;
         end
         MD_MULTU: begin
            prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            {res_hi, res_lo} = prod;
         end
         MD_DIV, MD_DIVU: begin
            res_hi = rem;
            res_lo = quot;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_iter.sv
// Fixed-latency MULT/DIV unit holding the architectural HI/LO registers; busy stalls MD-class ops.
module md_iter
   import md_iter_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   md_res_t           res_q,  res_d;
   logic              dz_q,   dz_d;
   logic [DATA_W-1:0] hi_q,   hi_d;
   logic [DATA_W-1:0] lo_q,   lo_d;

   md_res_t calc_res;
   logic    calc_dz;
   logic    busy_q;
   logic    start;

   md_calc u_calc (
      .op       (op),
      .a        (a),
      .b        (b),
      .res_hi   (calc_res.hi),
      .res_lo   (calc_res.lo),
      .div_zero (calc_dz)
   );

   assign busy_q = (cnt_q != '0);
   assign start  = md_is_start(op) && !busy_q;
   assign busy   = start || busy_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

   // Completion has priority; any op arriving while running is dropped.
   always_comb begin
      cnt_d = cnt_q;
      res_d = res_q;
      dz_d  = dz_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (start) begin
         res_d = calc_res;
         dz_d  = calc_dz;
         cnt_d = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_W'(1);
         if ((cnt_q == CNT_W'(1)) && !dz_q) begin
            hi_d = res_q.hi;
            lo_d = res_q.lo;
         end
      end else if (op == MD_MTHI) begin
         hi_d = a;
      end else if (op == MD_MTLO) begin
         lo_d = a;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         res_q <= '0;
         dz_q  <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         res_q <= res_d;
         dz_q  <= dz_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_iter.sv
// Randomized bench for md_iter against a cycle-numbered reference of HI/LO and busy windows.
module tb_md_iter;
   import md_iter_pkg::*;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   md_iter #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk  (clk),
      .rst  (rst),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk;
   int          n_fail;
   int          cyc;
   int          run_end;
   logic        pend_valid;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Reference arithmetic straight from the ISA definitions, returned as {hi, lo}.
   function automatic logic [63:0] ref_calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int          sx, sy;
      longint      sp;
      logic [63:0] up;
      sx = x;
      sy = y;
      case (o)
         MD_MULT: begin
            sp = longint'(sx) * longint'(sy);
            return 64'(sp);
         end
         MD_MULTU: begin
            up = {32'd0, x} * {32'd0, y};
            return up;
         end
         MD_DIV: begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         default: return {x % y, x / y};
      endcase
   endfunction

   function automatic logic is_mdstart(input logic [3:0] o);
      return o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU;
   endfunction

   // One clock cycle: drive, check outputs against the model, clock, advance the model.
   task automatic step(input logic r, input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
      logic        mbq;
      logic [63:0] rr;
      rst = r; op = o; a = av; b = bv;
      mbq = (cyc <= run_end);
      #1;
      chk("busy", 32'(busy), 32'(mbq || is_mdstart(o)));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      @(posedge clk);
      if (!r) begin
         m_hi = '0; m_lo = '0; run_end = -1; pend_valid = 1'b0;
      end else if (mbq) begin
         if (cyc == run_end && pend_valid) begin
            m_hi = p_hi; m_lo = p_lo;
         end
      end else if (is_mdstart(o)) begin
         rr = ref_calc(o, av, bv);
         p_hi = rr[63:32]; p_lo = rr[31:0];
         pend_valid = !((o == MD_DIV || o == MD_DIVU) && bv == 0);
         run_end = cyc + int'((o == MD_DIV || o == MD_DIVU) ? DIV_N : MULT_N);
      end else if (o == MD_MTHI) begin
         m_hi = av;
      end else if (o == MD_MTLO) begin
         m_lo = av;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, MD_NONE, $urandom, $urandom);
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] corner [6];
      corner = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 40));
      return $urandom;
   endfunction

   function automatic logic [3:0] pick_op();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 3)  return MD_MULT;
      if (r < 6)  return MD_MULTU;
      if (r < 8)  return MD_DIV;
      if (r < 10) return MD_DIVU;
      if (r < 12) return MD_MTHI;
      if (r < 14) return MD_MTLO;
      if (r < 16) return MD_NONE;
      if (r < 18) return ($urandom_range(0, 1) != 0) ? MD_MFHI : MD_MFLO;
      return 4'($urandom_range(9, 15));
   endfunction

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; run_end = -1; pend_valid = 1'b0;
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      rst = 1'b0; op = MD_MULT; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      step(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2);
      idle(5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);

      step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      idle(5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
      idle(10);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);

      step(1'b1, MD_DIVU, 32'd7, 32'd2);
      idle(10);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);

      step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(10);
      chk("divovf_hi", hi, 32'd0);
      chk("divovf_lo", lo, 32'h8000_0000);

      step(1'b1, MD_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi", hi, 32'h1234_5678);
      step(1'b1, MD_MTLO, 32'h9, 32'd0);
      chk("mtlo", lo, 32'h9);

      step(1'b1, MD_MTHI, 32'hAA, 32'd0);
      step(1'b1, MD_MTLO, 32'hBB, 32'd0);
      step(1'b1, MD_DIVU, 32'd5, 32'd0);
      step(1'b1, MD_MTHI, 32'h1, 32'd0);
      step(1'b1, MD_MULT, 32'd3, 32'd3);
      idle(7);
      step(1'b1, MD_MTLO, 32'h1, 32'd0);
      chk("dz_hi", hi, 32'hAA);
      chk("dz_lo", lo, 32'hBB);

      step(1'b1, MD_MULT, 32'd3, 32'd3);
      idle(1);
      step(1'b0, MD_NONE, 32'd0, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      idle(6);
      chk("late_lo", lo, 32'd0);

      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 59) != 0), pick_op(), pick_val(), pick_val());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
